// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer for the 5-stage core.
// Drives the PC enable and the stage-register controls.
// Resolves load-use hazards, taken-branch flushes and data-memory wait states.
// A wait-state watchdog freezes the pipeline on a memory timeout.
// Stall and flush activity is counted for performance monitoring.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// BOOT     | first cycle after reset, pipeline filled with bubbles
// RUN      | normal operation, controls decoded from hazard inputs
// MEM_WAIT | data memory is inserting wait states, watchdog counting
// FAULT    | memory timeout, pipeline frozen until reset
module pipeline_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_is_load,
  input  logic        ex_branch_taken,
  input  logic        ma_mem_access,
  input  logic        mem_ready,
  output logic        pc_ena,
  output logic [1:0]  ifid_ctl,
  output logic [1:0]  idex_ctl,
  output logic [1:0]  exma_ctl,
  output logic        ena_mawb,
  output logic        mem_fault,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
);

  localparam logic [1:0] CTL_FLUSH = 2'b00;
  localparam logic [1:0] CTL_LOAD  = 2'b01;
  localparam logic [1:0] CTL_HOLD  = 2'b10;

  // The stall that would make the count reach MEM_TIMEOUT goes to FAULT instead.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2,
    FAULT    = 2'd3
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] wait_cnt;

  logic mem_stall;
  logic load_use;
  logic active;
  logic stall_inc;
  logic flush_inc;

  assign mem_stall = ma_mem_access & ~mem_ready;
  assign load_use  = ex_is_load & (ex_rd != 5'd0) &
                     ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                      (id_uses_rs2 & (id_rs2 == ex_rd)));
  assign active    = (state == RUN) || (state == MEM_WAIT);

  // A memory stall masks any branch or load-use hazard until the stall clears.
  assign stall_inc = active & (mem_stall | (~ex_branch_taken & load_use));
  assign flush_inc = active & ~mem_stall & ex_branch_taken;

  // FAULT is terminal, so the flag can come straight from the state.
  assign mem_fault = (state == FAULT);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= BOOT;
    else     state <= state_nxt;
  end

  // Next-state and Mealy pipeline controls, in hazard priority order.
  always_comb begin
    state_nxt = state;
    pc_ena    = 1'b0;
    ifid_ctl  = CTL_FLUSH;
    idex_ctl  = CTL_FLUSH;
    exma_ctl  = CTL_FLUSH;
    ena_mawb  = 1'b0;
    case (state)
      BOOT: begin
        state_nxt = RUN;
      end
      RUN, MEM_WAIT: begin
        if (mem_stall) begin
          state_nxt = (wait_cnt == WAIT_LAST) ? FAULT : MEM_WAIT;
          ifid_ctl  = CTL_HOLD;
          idex_ctl  = CTL_HOLD;
          exma_ctl  = CTL_HOLD;
        end else begin
          state_nxt = RUN;
          ena_mawb  = 1'b1;
          exma_ctl  = CTL_LOAD;
          if (ex_branch_taken) begin
            // ID holds a wrong-path instruction, so a load-use match is irrelevant.
            pc_ena = 1'b1;
          end else if (load_use) begin
            ifid_ctl = CTL_HOLD;
          end else begin
            pc_ena   = 1'b1;
            ifid_ctl = CTL_LOAD;
            idex_ctl = CTL_LOAD;
          end
        end
      end
      FAULT: begin
        ifid_ctl = CTL_HOLD;
        idex_ctl = CTL_HOLD;
        exma_ctl = CTL_HOLD;
      end
      default: begin
        state_nxt = BOOT;
      end
    endcase
  end

  // Watchdog: counts consecutive memory-stall cycles, clears on any other cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    wait_cnt <= 8'd0;
    else if (active & mem_stall) wait_cnt <= wait_cnt + 8'd1;
    else                        wait_cnt <= 8'd0;
  end

  // Performance counters, wrapping modulo 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= 32'd0;
      flush_count  <= 32'd0;
    end else begin
      if (stall_inc) stall_cycles <= stall_cycles + 32'd1;
      if (flush_inc) flush_count  <= flush_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: the driver pushes hand-computed expectations,
// and the monitor pops and compares them on the falling edge of the same cycle.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic        id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0;
  logic        ex_is_load = 1'b0, ex_branch_taken = 1'b0;
  logic        ma_mem_access = 1'b0, mem_ready = 1'b0;
  logic        pc_ena, ena_mawb, mem_fault;
  logic [1:0]  ifid_ctl, idex_ctl, exma_ctl;
  logic [31:0] stall_cycles, flush_count;

  pipeline_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_branch_taken(ex_branch_taken),
    .ma_mem_access(ma_mem_access), .mem_ready(mem_ready),
    .pc_ena(pc_ena), .ifid_ctl(ifid_ctl), .idex_ctl(idex_ctl), .exma_ctl(exma_ctl),
    .ena_mawb(ena_mawb), .mem_fault(mem_fault),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       r;
    logic       ld;
    logic [4:0] rd;
    logic       u1;
    logic [4:0] rs1;
    logic       u2;
    logic [4:0] rs2;
    logic       br;
    logic       ma;
    logic       rdy;
  } stim_t;

  typedef struct {
    string       name;
    logic [7:0]  outs;   // {pc_ena, ifid, idex, exma, ena_mawb}
    logic        fault;
    logic [31:0] stalls;
    logic [31:0] flushes;
  } exp_t;

  localparam logic [7:0] O_BOOT = 8'b0_00_00_00_0;
  localparam logic [7:0] O_RUN  = 8'b1_01_01_01_1;
  localparam logic [7:0] O_LU   = 8'b0_10_00_01_1;
  localparam logic [7:0] O_BR   = 8'b1_00_00_01_1;
  localparam logic [7:0] O_HOLD = 8'b0_10_10_10_0;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic stim_t st(logic r, logic ld, logic [4:0] rd, logic u1, logic [4:0] rs1,
                               logic u2, logic [4:0] rs2, logic br, logic ma, logic rdy);
    stim_t s;
    s = '{r:r, ld:ld, rd:rd, u1:u1, rs1:rs1, u2:u2, rs2:rs2, br:br, ma:ma, rdy:rdy};
    return s;
  endfunction

  function automatic exp_t ex(string n, logic [7:0] o, logic f, logic [31:0] s, logic [31:0] fl);
    exp_t e;
    e.name = n; e.outs = o; e.fault = f; e.stalls = s; e.flushes = fl;
    return e;
  endfunction

  // One cycle: inputs change just after the rising edge, expectation queued for that cycle.
  task automatic drive(input stim_t s, input exp_t e);
    @(posedge clk);
    #1;
    rst = s.r; ex_is_load = s.ld; ex_rd = s.rd;
    id_uses_rs1 = s.u1; id_rs1 = s.rs1; id_uses_rs2 = s.u2; id_rs2 = s.rs2;
    ex_branch_taken = s.br; ma_mem_access = s.ma; mem_ready = s.rdy;
    sb.push_back(e);
  endtask

  // Monitor: the DUT presents a fresh Mealy output every cycle; check at mid-cycle.
  initial begin
    exp_t       e;
    logic [7:0] act;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        act = {pc_ena, ifid_ctl, idex_ctl, exma_ctl, ena_mawb};
        n_vec++;
        if (act !== e.outs || mem_fault !== e.fault ||
            stall_cycles !== e.stalls || flush_count !== e.flushes) begin
          n_miss++;
          $display("FAIL %s: got outs=%b fault=%b stalls=%h flushes=%h, expected outs=%b fault=%b stalls=%h flushes=%h",
                   e.name, act, mem_fault, stall_cycles, flush_count,
                   e.outs, e.fault, e.stalls, e.flushes);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    stim_t idle, idle_rst;
    int    drain;
    idle     = st(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0);
    idle_rst = st(1, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0);

    drive(idle_rst, ex("reset_held",   O_BOOT, 0, 0, 0));
    drive(idle,     ex("boot_cycle",   O_BOOT, 0, 0, 0));
    drive(idle,     ex("first_run",    O_RUN,  0, 0, 0));
    drive(st(0, 1, 5'd5, 0, 5'd0, 1, 5'd5, 0, 0, 0), ex("load_use_rs2",  O_LU,  0, 0, 0));
    drive(idle,     ex("after_lu",     O_RUN,  0, 1, 0));
    drive(st(0, 1, 5'd0, 1, 5'd0, 1, 5'd0, 0, 0, 0), ex("rd_zero",       O_RUN, 0, 1, 0));
    drive(st(0, 1, 5'd7, 1, 5'd7, 0, 5'd3, 0, 0, 0), ex("load_use_rs1",  O_LU,  0, 1, 0));
    drive(st(0, 1, 5'd7, 0, 5'd7, 0, 5'd7, 0, 0, 0), ex("unused_src",    O_RUN, 0, 2, 0));
    drive(st(0, 0, 5'd7, 1, 5'd7, 1, 5'd7, 0, 0, 0), ex("not_load",      O_RUN, 0, 2, 0));
    drive(st(0, 1, 5'd9, 1, 5'd9, 0, 5'd0, 1, 0, 0), ex("branch_vs_lu",  O_BR,  0, 2, 0));
    drive(idle,     ex("after_branch", O_RUN,  0, 2, 1));
    drive(st(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 1), ex("mem_ready_now", O_RUN,  0, 2, 1));
    drive(st(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 0), ex("mem_wait_1",    O_HOLD, 0, 2, 1));
    drive(st(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 1, 0), ex("wait_2_branch", O_HOLD, 0, 3, 1));
    drive(st(0, 1, 5'd4, 1, 5'd4, 0, 5'd0, 0, 1, 0), ex("wait_3_lu",     O_HOLD, 0, 4, 1));
    drive(st(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 1, 1), ex("wait_done_br",  O_BR,   0, 5, 1));
    drive(idle,     ex("after_wait",   O_RUN,  0, 5, 2));
    drive(st(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 0), ex("tmo_stall_1",   O_HOLD, 0, 5, 2));
    drive(st(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 0), ex("tmo_stall_2",   O_HOLD, 0, 6, 2));
    drive(st(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 0), ex("tmo_stall_3",   O_HOLD, 0, 7, 2));
    drive(st(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 0), ex("tmo_stall_4",   O_HOLD, 0, 8, 2));
    drive(st(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 0), ex("fault_entry",   O_HOLD, 1, 9, 2));
    drive(st(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 1), ex("fault_ready",   O_HOLD, 1, 9, 2));
    drive(st(0, 1, 5'd6, 1, 5'd6, 0, 5'd0, 1, 0, 0), ex("fault_frozen",  O_HOLD, 1, 9, 2));
    drive(idle_rst, ex("reset_fault",  O_BOOT, 0, 0, 0));
    drive(idle,     ex("boot_again",   O_BOOT, 0, 0, 0));
    drive(idle,     ex("run_again",    O_RUN,  0, 0, 0));

    @(posedge clk);
    #2 force dut.stall_cycles = 32'hFFFF_FFFF;
    #1 release dut.stall_cycles;
    drive(st(0, 1, 5'd5, 0, 5'd0, 1, 5'd5, 0, 0, 0), ex("wrap_lu",  O_LU,  0, 32'hFFFF_FFFF, 0));
    drive(idle,     ex("wrap_result",  O_RUN,  0, 32'h0000_0000, 0));

    drain = 0;
    while (sb.size() > 0 && drain < 10) begin
      @(posedge clk);
      drain++;
    end
    if (sb.size() > 0) begin
      n_miss++;
      $display("FAIL drain: got %0d pending expectations, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
